// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver that packs consecutive bytes into words,
// most significant part first, and queues finished words in a small FIFO
// drained by the core through a read-enable handshake.
module uart_word_rx #(
    parameter int WORD_SIZE = 32,
    parameter int WORD_PART = 8,
    parameter int MEM_SIZE  = 64,
    parameter int CLQ_FREQ  = 200_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 r_enable,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int CLKS_PER_BIT = CLQ_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int PARTS        = WORD_SIZE / WORD_PART;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = (WORD_PART > 1) ? $clog2(WORD_PART) : 1;
    localparam int PART_W       = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int PTR_W        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int OCC_W        = $clog2(MEM_SIZE + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_PART - 1);
    localparam logic [PART_W-1:0] PART_ONE  = PART_W'(1);
    localparam logic [PART_W-1:0] PART_LAST = PART_W'(PARTS - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_PART-1:0]   shift_q, shift_d;
    logic [PART_W-1:0]      part_cnt_q, part_cnt_d;
    logic [WORD_SIZE-1:0]   word_q, word_d;
    logic                   wr_pend_q, wr_pend_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       count_q, count_d;
    logic [WORD_SIZE-1:0]   data_out_q, data_out_d;
    logic                   valid_out_q, valid_out_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;
    logic [WORD_SIZE-1:0]   fifo_mem [MEM_SIZE];

    logic rx_s;
    logic timer_done;
    logic byte_done;
    logic do_pop;
    logic do_write;

    assign rx_s       = sync_q[1];
    assign timer_done = (state_q == START) ? (clk_cnt_q == HALF_LAST) : (clk_cnt_q == BIT_END);
    assign full       = (count_q == OCC_FULL);
    assign empty      = (count_q == '0);
    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

    // Receiver state register; reset drops any frame in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: start edge, glitch rejection, data bits, stop bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s) state_d = START;
            START: if (timer_done) state_d = rx_s ? IDLE : DATA;
            DATA:  if (timer_done && (bit_cnt_q == BIT_LAST)) state_d = STOP;
            STOP:  if (timer_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state outputs: bit timer, LSB-first shifting, byte strobe and framing error.
    always_comb begin
        sync_d      = {sync_q[0], rx};
        clk_cnt_d   = clk_cnt_q + CNT_ONE;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            START: begin
                if (timer_done) clk_cnt_d = '0;
            end
            DATA: begin
                if (timer_done) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[WORD_PART-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            STOP: begin
                if (timer_done) begin
                    clk_cnt_d = '0;
                    if (rx_s) byte_done   = 1'b1;
                    else      frame_err_d = 1'b1;
                end
            end
            default: clk_cnt_d = '0;
        endcase
    end

    // Word assembly and FIFO bookkeeping; a full FIFO drops the new word but a pop still happens.
    always_comb begin
        part_cnt_d = part_cnt_q;
        word_d     = word_q;
        wr_pend_d  = 1'b0;
        if (frame_err_d) begin
            part_cnt_d = '0;
            word_d     = '0;
        end else if (byte_done) begin
            word_d[WORD_SIZE-1-int'(part_cnt_q)*WORD_PART -: WORD_PART] = shift_q;
            if (part_cnt_q == PART_LAST) begin
                part_cnt_d = '0;
                wr_pend_d  = 1'b1;
            end else begin
                part_cnt_d = part_cnt_q + PART_ONE;
            end
        end

        do_pop      = r_enable && (count_q != '0);
        do_write    = wr_pend_q && (count_q != OCC_FULL);
        overflow_d  = wr_pend_q && (count_q == OCC_FULL);
        valid_out_d = do_pop;
        data_out_d  = do_pop ? fifo_mem[rd_ptr_q] : data_out_q;
        wr_ptr_d    = do_write ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = do_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d     = count_q;
        if (do_write && !do_pop)      count_d = count_q + OCC_ONE;
        else if (!do_write && do_pop) count_d = count_q - OCC_ONE;
    end

    // Datapath registers; the synchronizer idles high so reset never fakes a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            part_cnt_q  <= '0;
            word_q      <= '0;
            wr_pend_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            part_cnt_q  <= part_cnt_d;
            word_q      <= word_d;
            wr_pend_q   <= wr_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Word storage; contents need no reset because the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_write) fifo_mem[wr_ptr_q] <= word_q;
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: drives UART frames into uart_word_rx and checks popped
// words, pulses and flags against a queue-based model of the link.
`timescale 1ns/1ps
module tb_uart_word_rx;

    localparam int WORD_SIZE = 32;
    localparam int WORD_PART = 8;
    localparam int MEM_SIZE  = 4;
    localparam int CLQ_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = CLQ_FREQ / BAUD_RATE;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        r_enable = 1'b0;
    logic [31:0] data_out;
    logic        valid_out, full, empty, overflow, frame_err;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int ovf_seen = 0;
    int ferr_seen = 0;
    int ovf_exp = 0;
    int ferr_exp = 0;
    logic [31:0] model_q[$];
    logic [31:0] pop_q[$];
    logic [31:0] last_popped = 32'h0;

    uart_word_rx #(
        .WORD_SIZE(WORD_SIZE), .WORD_PART(WORD_PART), .MEM_SIZE(MEM_SIZE),
        .CLQ_FREQ(CLQ_FREQ), .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clock(clock), .reset(reset), .rx(rx), .r_enable(r_enable),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .overflow(overflow), .frame_err(frame_err)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    // Watchdog so the run always terminates.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required finish before 3 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Compare process: every popped word against the model, and pulse tallies.
    always @(negedge clock) begin
        if (!reset) begin
            if (valid_out) begin
                valid_seen++;
                if (pop_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: valid_out=1 with data 0x%08h, required no pulse", data_out);
                end else begin
                    check_output("pop_data", data_out, pop_q.pop_front());
                end
            end
            if (overflow)  ovf_seen++;
            if (frame_err) ferr_seen++;
        end
    end

    // One UART frame, optionally cut short, optionally raising r_enable at cycle pop_at.
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input int gap,
                                  input int pop_at, input int max_cycles);
        for (int k = 0; k < 10*CPB && k < max_cycles; k++) begin
            int bit_idx;
            @(posedge clock); #1;
            bit_idx = k / CPB;
            if (bit_idx == 0)      rx = 1'b0;
            else if (bit_idx <= 8) rx = b[bit_idx-1];
            else                   rx = stop_bit;
            if (pop_at >= 0) r_enable = (k == pop_at);
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
            rx = 1'b1;
        end
    endtask

    task automatic model_push(input logic [31:0] w);
        if (model_q.size() < MEM_SIZE) model_q.push_back(w);
        else                           ovf_exp++;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int p = 0; p < 4; p++) begin
            logic [7:0] b;
            b = w[31-8*p -: 8];
            apply_stimulus(b, 1'b1, $urandom_range(max_gap, 0), -1, 100000);
        end
        model_push(w);
    endtask

    task automatic pop_word();
        @(posedge clock); #1;
        r_enable = 1'b1;
        if (model_q.size() > 0) begin
            last_popped = model_q[0];
            pop_q.push_back(model_q.pop_front());
        end
        @(posedge clock); #1;
        r_enable = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        repeat (2) @(posedge clock);
        #1;
        check_output({tag, "_empty"}, {31'b0, empty}, {31'b0, model_q.size() == 0});
        check_output({tag, "_full"},  {31'b0, full},  {31'b0, model_q.size() == MEM_SIZE});
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_data_out"},  data_out, 32'h0);
        check_output({tag, "_valid_out"}, {31'b0, valid_out}, 32'h0);
        check_output({tag, "_full"},      {31'b0, full}, 32'h0);
        check_output({tag, "_empty"},     {31'b0, empty}, 32'h1);
        check_output({tag, "_overflow"},  {31'b0, overflow}, 32'h0);
        check_output({tag, "_frame_err"}, {31'b0, frame_err}, 32'h0);
    endtask

    initial begin
        int vs;
        logic [31:0] w;
        logic [31:0] words [5];

        $display("[TB] start");
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        repeat (5) @(posedge clock);

        // Back-to-back DE AD BE EF.
        $display("[TB] test: basic word");
        send_word(32'hDEADBEEF, 0);
        check_flags("basic");
        pop_word();
        check_output("basic_literal", data_out, 32'hDEADBEEF);
        check_flags("basic_after_pop");

        // Framing error then a clean word.
        $display("[TB] test: frame error");
        apply_stimulus(8'h12, 1'b0, 20, -1, 100000);
        ferr_exp++;
        send_word(32'h01020304, 5);
        check_output("ferr_count", ferr_seen, ferr_exp);
        check_flags("ferr");
        pop_word();
        check_output("ferr_literal", data_out, 32'h01020304);
        check_flags("ferr_after_pop");

        // Short low glitch must not start a byte.
        $display("[TB] test: glitch");
        @(posedge clock); #1; rx = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        rx = 1'b1;
        repeat (20) @(posedge clock);
        send_word(32'hCAFE5A17, 3);
        check_flags("glitch");
        pop_word();
        check_output("glitch_literal", data_out, 32'hCAFE5A17);
        check_output("glitch_ferr", ferr_seen, ferr_exp);
        check_flags("glitch_after_pop");

        // Five words without popping: full then one overflow.
        $display("[TB] test: overflow");
        for (int i = 0; i < 5; i++) words[i] = 32'h11111111 * (i + 1);
        for (int i = 0; i < 4; i++) send_word(words[i], 2);
        check_flags("fill4");
        check_output("fill4_full_literal", {31'b0, full}, 32'h1);
        send_word(words[4], 2);
        check_output("ovf_count", ovf_seen, ovf_exp);
        check_output("ovf_literal", ovf_seen, 32'd1);
        for (int i = 0; i < 4; i++) pop_word();
        check_output("ovf_last_word", data_out, 32'h44444444);
        check_flags("ovf_drained");

        // r_enable held while empty: nothing happens.
        $display("[TB] test: pop while empty");
        vs = valid_seen;
        @(posedge clock); #1; r_enable = 1'b1;
        repeat (8) @(posedge clock);
        #1; r_enable = 1'b0;
        @(negedge clock);
        check_output("empty_pop_valid", vs, valid_seen);
        check_output("empty_pop_hold", data_out, last_popped);

        // Pop on the same cycle as a write while full.
        $display("[TB] test: pop and write while full");
        for (int i = 0; i < 4; i++) send_word(32'hA0000000 + i, 1);
        check_flags("full_again");
        w = 32'hBADC0DE5;
        for (int p = 0; p < 3; p++) apply_stimulus(w[31-8*p -: 8], 1'b1, 0, -1, 100000);
        ovf_exp++;
        last_popped = model_q[0];
        pop_q.push_back(model_q.pop_front());
        apply_stimulus(w[7:0], 1'b1, 0, 10*CPB - 2, 100000);
        check_flags("simul");
        check_output("simul_ovf", ovf_seen, ovf_exp);
        for (int i = 0; i < 3; i++) begin
            pop_word();
            check_flags("simul_pop");
        end
        check_output("simul_last", data_out, 32'hA0000003);

        // Reset in the middle of a word.
        $display("[TB] test: reset mid-word");
        apply_stimulus(8'h77, 1'b1, 0, -1, 100000);
        apply_stimulus(8'h88, 1'b1, 0, -1, 100000);
        apply_stimulus(8'hA5, 1'b1, 0, -1, 4*CPB + 5);
        #2; reset = 1'b1;
        rx = 1'b1;
        #2;
        check_reset_values("midreset");
        model_q.delete();
        pop_q.delete();
        repeat (3) @(posedge clock);
        #1; reset = 1'b0;
        repeat (5) @(posedge clock);
        send_word(32'h0BADF00D, 0);
        check_flags("postreset");
        pop_word();
        check_output("postreset_literal", data_out, 32'h0BADF00D);
        check_flags("postreset_after_pop");

        // Randomized traffic with random pops and gaps.
        $display("[TB] test: random traffic");
        for (int n = 0; n < 20; n++) begin
            send_word($urandom, 20);
            check_flags("rand");
            repeat ($urandom_range(2, 0)) pop_word();
        end
        while (model_q.size() > 0) pop_word();
        check_flags("rand_drained");

        repeat (10) @(posedge clock);
        check_output("final_pending_pops", pop_q.size(), 32'd0);
        check_output("final_ovf", ovf_seen, ovf_exp);
        check_output("final_ferr", ferr_seen, ferr_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
